// File: rtl/mdu_unit.sv
// Multiply/divide unit for the E stage: holds architectural HI/LO, computes the
// result at Start, and releases it into HI/LO after a fixed busy latency.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [3:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        HIWrite,
  input  logic        LOWrite,
  input  logic        HIRead,
  input  logic        LORead,
  output logic        Busy,
  output logic [31:0] Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BUSY  = 1'b1;
  localparam logic [3:0] MULT_LD = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LD  = 4'(DIV_CYCLES);

  logic [0:0]  state;
  logic [3:0]  cnt;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_p0, pend_lo_p0;
  logic [63:0] res;
  logic        is_div;

  // Signed divide on magnitudes so that 0x80000000 / -1 wraps cleanly to
  // 0x80000000; returns {remainder, quotient}.
  function automatic logic [63:0] sdiv(input logic [31:0] n, input logic [31:0] d);
    logic [31:0] mn, md, q, r;
    mn = n[31] ? (~n + 32'd1) : n;
    md = d[31] ? (~d + 32'd1) : d;
    q  = mn / md;
    r  = mn % md;
    if (n[31] ^ d[31]) q = ~q + 32'd1;
    if (n[31])         r = ~r + 32'd1;
    return {r, q};
  endfunction

  logic signed [63:0] a_sx, b_sx, prod_s;
  logic        [63:0] prod_u;

  assign a_sx   = $signed({{32{A[31]}}, A});
  assign b_sx   = $signed({{32{B[31]}}, B});
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, A} * {32'd0, B};
  assign is_div = (MDUOp == 4'd2) || (MDUOp == 4'd3);

  // Divide by zero latches the current HI/LO so completion leaves them unchanged.
  always_comb begin
    res = prod_s;
    case (MDUOp)
      4'd1:    res = prod_u;
      4'd2:    res = (B == 32'd0) ? {hi_q, lo_q} : sdiv(A, B);
      4'd3:    res = (B == 32'd0) ? {hi_q, lo_q} : {A % B, A / B};
      default: res = prod_s;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      pend_hi_p0 <= 32'd0;
      pend_lo_p0 <= 32'd0;
    end else if (state == S_IDLE) begin
      if (Start) begin
        pend_hi_p0 <= res[63:32];
        pend_lo_p0 <= res[31:0];
        cnt        <= is_div ? DIV_LD : MULT_LD;
        state      <= S_BUSY;
      end else begin
        if (HIWrite) hi_q <= A;
        if (LOWrite) lo_q <= A;
      end
    end else begin
      // Busy stage: count down, commit pending result on the last cycle
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi_q  <= pend_hi_p0;
        lo_q  <= pend_lo_p0;
        state <= S_IDLE;
      end
    end
  end

  assign Busy = (state == S_BUSY);
  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Out  = HIRead ? hi_q : (LORead ? lo_q : 32'h0);

endmodule

// File: tb/tb_mdu_unit.sv
// Randomised + directed bench for mdu_unit against a cycle-stamped behavioural model.
module tb_mdu_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [3:0]  MDUOp;
  logic [31:0] A, B;
  logic        HIWrite, LOWrite, HIRead, LORead;
  logic        Busy;
  logic [31:0] Out, HI, LO;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOp(MDUOp), .A(A), .B(B),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HIRead(HIRead), .LORead(LORead),
    .Busy(Busy), .Out(Out), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 0;
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  longint      cyc = 0;
  longint      commit_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result from plain 64-bit integer arithmetic.
  task automatic model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] nh, output logic [31:0] nl);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = a;
    ub = b;
    nh = m_hi;
    nl = m_lo;
    case (op)
      4'd1: begin p = ua * ub; nh = p[63:32]; nl = p[31:0]; end
      4'd2: if (b != 0) begin q = sa / sb; r = sa % sb; nh = r[31:0]; nl = q[31:0]; end
      4'd3: if (b != 0) begin nl = a / b; nh = a % b; end
      default: begin q = sa * sb; nh = q[63:32]; nl = q[31:0]; end
    endcase
  endtask

  task automatic model_clear();
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
    commit_cyc = cyc;
  endtask

  task automatic cycle(input bit st, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit hw, input bit lw, input bit hr, input bit lr);
    bit busy_prev;
    Start = st; MDUOp = op; A = a; B = b;
    HIWrite = hw; LOWrite = lw; HIRead = hr; LORead = lr;
    @(posedge clk);
    busy_prev = (cyc < commit_cyc);
    cyc++;
    if (reset) begin
      if (busy_prev) begin
        if (cyc == commit_cyc) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (st) begin
        model_result(op, a, b, m_phi, m_plo);
        commit_cyc = cyc + ((op == 4'd2 || op == 4'd3) ? 10 : 5);
      end else begin
        if (hw) m_hi = a;
        if (lw) m_lo = a;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 4'd0, $urandom, $urandom, 0, 0, i[0], 0);
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = (op == 4'd2 || op == 4'd3) ? 10 : 5;
    cycle(1, op, a, b, 0, 0, 0, 0);
    check("busy_after_start", {31'd0, Busy}, 32'd1);
    for (int i = 0; i < n; i++) cycle(0, 4'd0, 32'd0, 32'd0, 0, 0, (i == 0), 0);
  endtask

  task automatic pin(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, HI, eh);
    check({name, "_lo"}, LO, el);
    check({name, "_model_hi"}, m_hi, eh);
    check({name, "_model_lo"}, m_lo, el);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, Busy}, {31'd0, (cyc < commit_cyc)});
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
      check("out", Out, HIRead ? m_hi : (LORead ? m_lo : 32'h0));
    end
  end

  initial begin
    reset = 1; Start = 0; MDUOp = 0; A = 0; B = 0;
    HIWrite = 0; LOWrite = 0; HIRead = 0; LORead = 0;
    #2 reset = 0;
    model_clear();
    chk_en = 1;
    cycle(0, 4'd0, 32'hFFFF_FFFF, 32'd1, 1, 1, 0, 0);
    cycle(0, 4'd0, 32'd0, 32'd0, 0, 0, 1, 0);
    check("reset_busy", {31'd0, Busy}, 32'd0);
    check("reset_out", Out, 32'd0);
    pin("reset", 32'd0, 32'd0);
    reset = 1;
    idle(3);
    pin("post_reset", 32'd0, 32'd0);

    run_op(4'd0, 32'hFFFF_FFFE, 32'd3);
    pin("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
    pin("multu", 32'h0000_0002, 32'hFFFF_FFFA);
    run_op(4'd3, 32'd7, 32'd2);
    pin("divu", 32'd1, 32'd3);
    run_op(4'd2, 32'hFFFF_FFF9, 32'd2);
    pin("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    pin("div_ovf", 32'h0, 32'h8000_0000);
    run_op(4'd2, 32'd5, 32'd0);
    pin("div_zero", 32'h0, 32'h8000_0000);

    cycle(0, 4'd0, 32'h1234_5678, 32'd0, 1, 0, 0, 0);
    pin("mthi", 32'h1234_5678, 32'h8000_0000);
    cycle(0, 4'd0, 32'hCAFE_BABE, 32'd0, 0, 1, 0, 1);
    check("mflo_out", Out, 32'hCAFE_BABE);
    cycle(0, 4'd0, 32'd0, 32'd0, 1, 1, 1, 1);
    check("mfhi_prio", Out, 32'd0);
    cycle(1, 4'd0, 32'd2, 32'd3, 0, 0, 0, 0);
    cycle(0, 4'd0, 32'hDEAD_BEEF, 32'd0, 1, 1, 0, 0);
    idle(5);
    pin("write_in_busy", 32'd0, 32'd6);

    for (int i = 0; i < 500; i++) begin
      bit          st, is_idle;
      logic [3:0]  op;
      logic [31:0] a, b;
      is_idle = (cyc >= commit_cyc);
      st = is_idle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
      op = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom;
      b  = ($urandom_range(0, 6) == 0) ? 32'd0 :
           (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : $urandom);
      cycle(st, op, a, b, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    for (int i = 0; i < 20 && cyc < commit_cyc; i++) idle(1);
    check("drain_idle", {31'd0, Busy}, 32'd0);
    cycle(0, 4'd0, 32'h1111_2222, 32'd0, 1, 1, 0, 0);
    run_op(4'd0, 32'd3, 32'd3);
    cycle(1, 4'd2, 32'd100, 32'd7, 0, 0, 0, 0);
    idle(3);
    #2 reset = 0;
    model_clear();
    #1;
    check("midreset_busy", {31'd0, Busy}, 32'd0);
    pin("midreset", 32'd0, 32'd0);
    idle(2);
    reset = 1;
    idle(15);
    pin("after_midreset", 32'd0, 32'd0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
